prbs5_checker: RTL and testbench

//   Serial checker for the 5-bit PRSG stream (x^5+x^3+1, period 31), placed directly downstream of prsg.

---
 rtl/prbs5_if.sv | 12 +
 rtl/prbs5_checker.sv | 105 ++++++++++
 tb/tb_prbs5_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/prbs5_if.sv
// prbs5_if: serial bit stream into the PRBS5 checker and its status/counter outputs.
interface prbs5_if #(parameter int CNT_W = 16);
  logic             bit_in;
  logic             bit_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  modport master (output bit_in, bit_valid, clr_cnt, input locked, err_pulse, err_count, bit_count);
  modport slave (input bit_in, bit_valid, clr_cnt, output locked, err_pulse, err_count, bit_count);
endinterface

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising x^5+x^3+1 checker with flywheel lock, error counting and loss-of-lock.
module prbs5_checker #(
  parameter int SYNC_LEN    = 8,
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW      = 31,
  parameter int CNT_W       = 16
) (
  input logic   clk,
  input logic   rst,
  prbs5_if.slave s
);
  localparam int WB_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
  state_t           r_state, w_state_n;
  logic [4:0]       r_h, w_h_n;
  logic [7:0]       r_match, w_match_n;
  logic [WB_W-1:0]  r_win_bits, w_win_bits_n;
  logic [WE_W-1:0]  r_win_err, w_win_err_n;
  logic             r_locked, w_locked_n, r_pulse, w_pulse_n;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_n, r_bit_cnt, w_bit_cnt_n;
  logic             w_p, w_mis;
  assign w_p   = r_h[4] ^ r_h[2];
  assign w_mis = s.bit_in != w_p;
  always_comb begin
    w_state_n    = r_state;
    w_h_n        = r_h;
    w_match_n    = r_match;
    w_win_bits_n = r_win_bits;
    w_win_err_n  = r_win_err;
    w_locked_n   = r_locked;
    w_pulse_n    = 1'b0;
    w_err_cnt_n  = r_err_cnt;
    w_bit_cnt_n  = r_bit_cnt;
    if (s.bit_valid)
      case (r_state)
        FILL: begin
          w_h_n     = {r_h[3:0], s.bit_in};
          w_match_n = (r_match == 8'd4) ? 8'd0 : r_match + 8'd1;
          w_state_n = (r_match == 8'd4) ? SEARCH : FILL;
        end
        SEARCH: begin
          w_h_n     = {r_h[3:0], s.bit_in};
          w_match_n = (!w_mis && r_h != 5'd0) ? r_match + 8'd1 : 8'd0;
          if (w_match_n == 8'(SYNC_LEN)) begin
            w_state_n    = LOCKED;
            w_locked_n   = 1'b1;
            w_match_n    = 8'd0;
            w_win_bits_n = '0;
            w_win_err_n  = '0;
          end
        end
        LOCKED: begin
          // flywheel: shift the prediction, so a corrupted input bit never poisons later predictions
          w_h_n        = {r_h[3:0], w_p};
          w_pulse_n    = w_mis;
          w_bit_cnt_n  = (r_bit_cnt == CNT_MAX) ? r_bit_cnt : r_bit_cnt + 1'b1;
          w_err_cnt_n  = (w_mis && r_err_cnt != CNT_MAX) ? r_err_cnt + 1'b1 : r_err_cnt;
          w_win_bits_n = r_win_bits + 1'b1;
          w_win_err_n  = r_win_err + WE_W'(w_mis);
          if (w_win_err_n == WE_W'(LOSS_THRESH)) begin
            w_state_n    = FILL;
            w_locked_n   = 1'b0;
            w_h_n        = 5'd0;
            w_match_n    = 8'd0;
            w_win_bits_n = '0;
            w_win_err_n  = '0;
          end else if (w_win_bits_n == WB_W'(WINDOW)) begin
            w_win_bits_n = '0;
            w_win_err_n  = '0;
          end
        end
        default: w_state_n = FILL;
      endcase
    w_err_cnt_n = s.clr_cnt ? '0 : w_err_cnt_n;
    w_bit_cnt_n = s.clr_cnt ? '0 : w_bit_cnt_n;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= FILL;
      r_h        <= 5'd0;
      r_match    <= 8'd0;
      r_win_bits <= '0;
      r_win_err  <= '0;
      r_locked   <= 1'b0;
      r_pulse    <= 1'b0;
      r_err_cnt  <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_h        <= w_h_n;
      r_match    <= w_match_n;
      r_win_bits <= w_win_bits_n;
      r_win_err  <= w_win_err_n;
      r_locked   <= w_locked_n;
      r_pulse    <= w_pulse_n;
      r_err_cnt  <= w_err_cnt_n;
      r_bit_cnt  <= w_bit_cnt_n;
    end
  assign s.locked    = r_locked;
  assign s.err_pulse = r_pulse;
  assign s.err_count = r_err_cnt;
  assign s.bit_count = r_bit_cnt;
endmodule

// File: tb/tb_prbs5_checker.sv
// tb_prbs5_checker: directed vectors and corner sequences for prbs5_checker.
module tb_prbs5_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  prbs5_if #(.CNT_W(16)) m_if ();
  prbs5_if #(.CNT_W(4))  s_if ();
  assign s_if.bit_in    = m_if.bit_in;
  assign s_if.bit_valid = m_if.bit_valid;
  assign s_if.clr_cnt   = m_if.clr_cnt;
  prbs5_checker #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .s(m_if));
  prbs5_checker #(.CNT_W(4))  u_sat (.clk(clk), .rst(rst), .s(s_if));
  typedef struct {
    logic v, flip, clr, e_lock, e_pulse;
    int   e_err, e_bits;
  } vec_t;
  vec_t       tbl[16];
  logic [4:0] g;
  logic       zero_mode = 1'b0;
  int         n_checks = 0, n_errs = 0, pulses = 0, lost = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic beat(input logic v, input logic flip, input logic c);
    logic b;
    @(negedge clk);
    b = $urandom_range(0, 1);
    if (v) begin
      b = zero_mode ? 1'b0 : g[4];
      g = {g[3:0], g[4] ^ g[2]};
    end
    m_if.bit_in    = b ^ flip;
    m_if.bit_valid = v;
    m_if.clr_cnt   = c;
    @(posedge clk);
    #1;
    if (m_if.err_pulse) pulses++;
    if (!m_if.locked) lost++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_if.bit_valid = 1'b0;
    m_if.clr_cnt   = 1'b0;
    m_if.bit_in    = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    g = 5'h1f;
  endtask
  task automatic relock(input string nm);
    do_reset();
    for (int i = 0; i < 13; i++) beat(1'b1, 1'b0, 1'b0);
    chk(nm, int'(m_if.locked), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int k = 0; k < 16; k++)
      tbl[k] = '{1'b1, 1'b0, 1'b0, logic'(k >= 12), 1'b0, 0, (k >= 12) ? k - 12 : 0};
    // T1: reset state, then clean lock
    do_reset();
    chk("rst_locked", int'(m_if.locked), 0);
    chk("rst_pulse", int'(m_if.err_pulse), 0);
    chk("rst_err", int'(m_if.err_count), 0);
    chk("rst_bits", int'(m_if.bit_count), 0);
    foreach (tbl[k]) begin
      beat(tbl[k].v, tbl[k].flip, tbl[k].clr);
      chk($sformatf("t1_lock[%0d]", k), int'(m_if.locked), int'(tbl[k].e_lock));
      chk($sformatf("t1_pulse[%0d]", k), int'(m_if.err_pulse), int'(tbl[k].e_pulse));
      chk($sformatf("t1_err[%0d]", k), int'(m_if.err_count), tbl[k].e_err);
      chk($sformatf("t1_bits[%0d]", k), int'(m_if.bit_count), tbl[k].e_bits);
    end
    for (int n = 17; n <= 100; n++) beat(1'b1, 1'b0, 1'b0);
    chk("t1_err100", int'(m_if.err_count), 0);
    chk("t1_bits100", int'(m_if.bit_count), 87);
    chk("sat_bits", int'(s_if.bit_count), 15);
    // T2: single inverted bit while locked
    pulses = 0;
    lost = 0;
    beat(1'b1, 1'b1, 1'b0);
    chk("t2_pulse", int'(m_if.err_pulse), 1);
    chk("t2_err", int'(m_if.err_count), 1);
    for (int n = 0; n < 40; n++) beat(1'b1, 1'b0, 1'b0);
    chk("t2_pulses", pulses, 1);
    chk("t2_err_after", int'(m_if.err_count), 1);
    chk("t2_lost", lost, 0);
    // T3: four consecutive errors drop lock, then relock after 13 clean bits
    relock("t3_lock");
    for (int n = 0; n < 4; n++) begin
      beat(1'b1, 1'b1, 1'b0);
      chk($sformatf("t3_pulse[%0d]", n), int'(m_if.err_pulse), 1);
      chk($sformatf("t3_lock[%0d]", n), int'(m_if.locked), n < 3 ? 1 : 0);
    end
    chk("t3_err", int'(m_if.err_count), 4);
    for (int n = 0; n < 12; n++) beat(1'b1, 1'b0, 1'b0);
    chk("t3_relock_12", int'(m_if.locked), 0);
    beat(1'b1, 1'b0, 1'b0);
    chk("t3_relock_13", int'(m_if.locked), 1);
    chk("t3_err_kept", int'(m_if.err_count), 4);
    // T4: three errors per window, straddling window boundaries
    relock("t4_lock");
    lost = 0;
    for (int n = 14; n <= 110; n++)
      beat(1'b1, logic'(n inside {42, 43, 44, 45, 46, 47, 76, 77, 78}), 1'b0);
    chk("t4_lost", lost, 0);
    chk("t4_err", int'(m_if.err_count), 9);
    // T5: all-zero stream never locks
    do_reset();
    zero_mode = 1'b1;
    lost = 0;
    for (int n = 0; n < 200; n++) beat(1'b1, 1'b0, 1'b0);
    zero_mode = 1'b0;
    chk("t5_unlocked", lost, 200);
    chk("t5_err", int'(m_if.err_count), 0);
    // T6: 1-in-3 valid, clear on errored beat, reset while locked
    do_reset();
    for (int i = 0; i < 13; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      chk($sformatf("t6_lock[%0d]", i), int'(m_if.locked), i >= 12 ? 1 : 0);
      beat(1'b0, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0);
      chk($sformatf("t6_idle[%0d]", i), int'(m_if.locked), i >= 12 ? 1 : 0);
    end
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    chk("t6_bits", int'(m_if.bit_count), 2);
    beat(1'b1, 1'b1, 1'b1);
    chk("t6_clr_err", int'(m_if.err_count), 0);
    chk("t6_clr_bits", int'(m_if.bit_count), 0);
    chk("t6_clr_pulse", int'(m_if.err_pulse), 1);
    chk("t6_clr_lock", int'(m_if.locked), 1);
    beat(1'b1, 1'b0, 1'b0);
    chk("t6_post_bits", int'(m_if.bit_count), 1);
    chk("t6_post_pulse", int'(m_if.err_pulse), 0);
    @(negedge clk);
    rst = 1'b1;
    m_if.bit_valid = 1'b1;
    m_if.bit_in    = g[4];
    @(posedge clk);
    #1;
    chk("t6_rst_lock", int'(m_if.locked), 0);
    chk("t6_rst_err", int'(m_if.err_count), 0);
    chk("t6_rst_bits", int'(m_if.bit_count), 0);
    @(negedge clk);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
